// File: rtl/yoda_pkg.sv
// Shared definitions for the encrypter array: sizes, collector state encoding and
// the helper that maps collector states onto the 2-bit watcher code.
package yoda_pkg;

    localparam int NUM_ENCRYPTERS     = 4;
    localparam int ENCRYPTER_WIDTH    = 32;
    localparam int NIBBLES_PER_PACKET = ENCRYPTER_WIDTH / 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_CHECK = 3'd4
    } collector_state_t;

    // CHECK is still a transmit phase, so the watcher reports it as SHIFT.
    function automatic logic [1:0] state_code(input collector_state_t s);
        case (s)
            ST_IDLE:  state_code = 2'd0;
            ST_WAIT:  state_code = 2'd1;
            ST_SHIFT: state_code = 2'd2;
            ST_DONE:  state_code = 2'd3;
            ST_CHECK: state_code = 2'd2;
            default:  state_code = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/nibble_shifter.sv
// W-bit packet register that shifts left one nibble per transfer, with a nibble
// counter flagging the last nibble. head_next is the top nibble after this edge.
module nibble_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic [3:0]       head_next,
    output logic             last
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next packet contents and nibble position; only a load restarts the count.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load) begin
            data_d = load_data;
            cnt_d  = '0;
        end else if (shift) begin
            data_d = {data_q[WIDTH-5:0], 4'h0};
            cnt_d  = cnt_q + CNT_W'(1);
        end else begin
            data_d = data_q;
            cnt_d  = cnt_q;
        end
    end

    // Packet and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_next = data_d[WIDTH-1 -: 4];
    assign last      = (cnt_q == CNT_W'(NIB - 1));

endmodule

// File: rtl/encrypter_collector.sv
// Round-robin collector: captures one packet per encrypter in dispatch order and
// streams it MSB nibble first over a valid/ready port. Optional trailing XOR
// checksum nibble when COLLECTOR_CHECKSUM_EN is defined.
module encrypter_collector #(
    parameter int NUM_ENCRYPTERS  = yoda_pkg::NUM_ENCRYPTERS,
    parameter int ENCRYPTER_WIDTH = yoda_pkg::ENCRYPTER_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           start,
    input  logic [15:0]                                    packet_count,
    input  logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0] encrypters_result,
    input  logic [NUM_ENCRYPTERS-1:0]                      encrypters_result_valid,
    output logic [NUM_ENCRYPTERS-1:0]                      encrypters_result_ack,
    output logic [3:0]                                     qspi_data,
    output logic                                           qspi_valid,
    input  logic                                           qspi_ready,
    output logic                                           busy,
    output logic                                           done,
    output logic [1:0]                                     state_out,
    output logic [$clog2(NUM_ENCRYPTERS)-1:0]              encrypter_index_out
);

    import yoda_pkg::*;

    localparam int IDX_W = $clog2(NUM_ENCRYPTERS);

`ifdef COLLECTOR_CHECKSUM_EN
    localparam collector_state_t END_STATE = ST_CHECK;
`else
    localparam collector_state_t END_STATE = ST_DONE;
`endif

    collector_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      remaining_q, remaining_d;

    logic [NUM_ENCRYPTERS-1:0] ack_q, ack_d;
    logic [3:0]       qspi_data_q, qspi_data_d;
    logic             qspi_valid_q, qspi_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       state_out_q, state_out_d;
    logic [IDX_W-1:0] idx_out_q, idx_out_d;

    logic       xfer_s, capture_s, last_s, shift_s;
    logic [3:0] head_next_s, checksum_s;

    assign xfer_s    = qspi_valid_q & qspi_ready;
    assign capture_s = (state_q == ST_WAIT) & encrypters_result_valid[idx_q];
    assign shift_s   = (state_q == ST_SHIFT) & xfer_s & ~last_s;

    nibble_shifter #(
        .WIDTH (ENCRYPTER_WIDTH)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (capture_s),
        .shift     (shift_s),
        .load_data (encrypters_result[idx_q]),
        .head_next (head_next_s),
        .last      (last_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (packet_count != 16'd0) ? ST_WAIT : END_STATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (encrypters_result_valid[idx_q]) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SHIFT: begin
                if (xfer_s && last_s) begin
                    state_d = (remaining_q == 16'd1) ? END_STATE : ST_WAIT;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                if (xfer_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Run bookkeeping: packets left and the encrypter being served.
    always_comb begin
        remaining_d = remaining_q;
        idx_d       = idx_q;
        if (state_q == ST_IDLE && start) begin
            remaining_d = packet_count;
            idx_d       = '0;
        end else if (state_q == ST_SHIFT && xfer_s && last_s) begin
            remaining_d = remaining_q - 16'd1;
            idx_d       = (idx_q == IDX_W'(NUM_ENCRYPTERS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            remaining_d = remaining_q;
            idx_d       = idx_q;
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_q <= 16'd0;
            idx_q       <= '0;
        end else begin
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
        end
    end

`ifdef COLLECTOR_CHECKSUM_EN
    logic [3:0] acc_q, acc_d;

    // Running XOR of every data nibble accepted by the transmitter this run.
    always_comb begin
        acc_d = acc_q;
        if (state_q == ST_IDLE && start) begin
            acc_d = 4'h0;
        end else if (state_q == ST_SHIFT && xfer_s) begin
            acc_d = acc_q ^ qspi_data_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= 4'h0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign checksum_s = acc_d;
`else
    assign checksum_s = 4'h0;
`endif

    // Output decode from the next state, so every output is a flop.
    always_comb begin
        ack_d = '0;
        if (capture_s) begin
            ack_d[idx_q] = 1'b1;
        end else begin
            ack_d = '0;
        end
        qspi_valid_d = (state_d == ST_SHIFT) || (state_d == ST_CHECK);
        if (!qspi_valid_d) begin
            qspi_data_d = 4'h0;
        end else if (capture_s || shift_s) begin
            qspi_data_d = head_next_s;
        end else if (state_d == ST_CHECK && state_q != ST_CHECK) begin
            qspi_data_d = checksum_s;
        end else begin
            qspi_data_d = qspi_data_q;
        end
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        state_out_d = state_code(state_d);
        idx_out_d   = idx_d;
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q        <= '0;
            qspi_data_q  <= 4'h0;
            qspi_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            state_out_q  <= 2'd0;
            idx_out_q    <= '0;
        end else begin
            ack_q        <= ack_d;
            qspi_data_q  <= qspi_data_d;
            qspi_valid_q <= qspi_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            state_out_q  <= state_out_d;
            idx_out_q    <= idx_out_d;
        end
    end

    assign encrypters_result_ack = ack_q;
    assign qspi_data             = qspi_data_q;
    assign qspi_valid            = qspi_valid_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign state_out             = state_out_q;
    assign encrypter_index_out   = idx_out_q;

endmodule

// File: tb/tb_encrypter_collector.sv
// Directed-vector bench for encrypter_collector (N=4, W=32). Expected nibble
// streams are built from hand-chosen packet values; checksum build adds the XOR nibble.
module tb_encrypter_collector;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [15:0]      packet_count;
    logic [3:0][31:0] encrypters_result;
    logic [3:0]       encrypters_result_valid;
    logic [3:0]       encrypters_result_ack;
    logic [3:0]       qspi_data;
    logic             qspi_valid;
    logic             qspi_ready;
    logic             busy;
    logic             done;
    logic [1:0]       state_out;
    logic [1:0]       encrypter_index_out;

    encrypter_collector dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .packet_count            (packet_count),
        .encrypters_result       (encrypters_result),
        .encrypters_result_valid (encrypters_result_valid),
        .encrypters_result_ack   (encrypters_result_ack),
        .qspi_data               (qspi_data),
        .qspi_valid              (qspi_valid),
        .qspi_ready              (qspi_ready),
        .busy                    (busy),
        .done                    (done),
        .state_out               (state_out),
        .encrypter_index_out     (encrypter_index_out)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  got[$];
    logic [3:0]  exp_q[$];
    int          ack_order[$];
    int          ack_cnt[4];
    int          ack_total = 0;
    int          done_cnt = 0;
    logic [1:0]  idx_at_done;
    logic [31:0] pkt_val[6];
    int          feed_next[4];
    int          feed_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_vec++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    // Observe transfers, acks and done away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (qspi_valid && qspi_ready) got.push_back(qspi_data);
            if (done) begin
                done_cnt++;
                idx_at_done = encrypter_index_out;
            end
            for (int i = 0; i < 4; i++) begin
                if (encrypters_result_ack[i]) begin
                    ack_cnt[i]++;
                    ack_total++;
                    ack_order.push_back(i);
                end
            end
        end
    end

    // Advance one cycle; the encrypter model reacts to the ack it sees.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (encrypters_result_ack[i]) begin
                feed_next[i] += 4;
                if (feed_next[i] < feed_total) begin
                    encrypters_result[i] = pkt_val[feed_next[i]];
                end else begin
                    encrypters_result_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic arm(input int total);
        feed_total = total;
        for (int i = 0; i < 4; i++) begin
            feed_next[i] = i;
            if (i < total) begin
                encrypters_result[i]       = pkt_val[i];
                encrypters_result_valid[i] = 1'b1;
            end else begin
                encrypters_result_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic manual();
        feed_total = 0;
        for (int i = 0; i < 4; i++) feed_next[i] = i;
        encrypters_result_valid = 4'h0;
    endtask

    task automatic clear_logs();
        got.delete();
        exp_q.delete();
        ack_order.delete();
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    endtask

    task automatic push_pkt(input logic [31:0] w);
        for (int k = 7; k >= 0; k--) exp_q.push_back(w[k*4 +: 4]);
    endtask

    task automatic finish_exp();
`ifdef COLLECTOR_CHECKSUM_EN
        logic [3:0] x;
        x = 4'h0;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
`endif
    endtask

    task automatic start_run(input logic [15:0] cnt);
        packet_count = cnt;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int c;
        d0 = done_cnt;
        c  = 0;
        while (done_cnt == d0 && c < budget) begin
            tick();
            c++;
        end
        repeat (3) tick();
        check(tag, done_cnt - d0, 1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < got.size()) check($sformatf("%s_nib%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        packet_count = 16'd0;
        encrypters_result = '0;
        encrypters_result_valid = 4'h0;
        qspi_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed_next[i] = i;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: reset state, then an empty run
        check("rst_valid", qspi_valid, 1'b0);
        check("rst_data", qspi_data, 4'h0);
        check("rst_ack", encrypters_result_ack, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", state_out, 2'd0);
        check("rst_idx", encrypter_index_out, 2'd0);
        qspi_ready = 1'b1;
        clear_logs();
        finish_exp();
        start_run(16'd0);
        wait_done("t1_done", 10);
        compare_stream("t1");
        check("t1_acks", ack_order.size(), 0);
        check("t1_busy", busy, 1'b0);

        // 2: four packets back to back
        pkt_val[0] = 32'h11111111; pkt_val[1] = 32'h22222222;
        pkt_val[2] = 32'h33333333; pkt_val[3] = 32'h44444444;
        clear_logs();
        arm(4);
        push_pkt(32'h11111111); push_pkt(32'h22222222);
        push_pkt(32'h33333333); push_pkt(32'h44444444);
        finish_exp();
        start_run(16'd4);
        wait_done("t2_done", 100);
        compare_stream("t2");
        for (int i = 0; i < 4; i++) check($sformatf("t2_ack%0d", i), ack_cnt[i], 1);

        // 3: out-of-order valids must not be served out of order
        manual();
        clear_logs();
        encrypters_result[0] = 32'h0A0A0A0A;
        encrypters_result[1] = 32'h1B1B1B1B;
        encrypters_result[2] = 32'h2C2C2C2C;
        push_pkt(32'h0A0A0A0A); push_pkt(32'h1B1B1B1B); push_pkt(32'h2C2C2C2C);
        finish_exp();
        start_run(16'd3);
        encrypters_result_valid[2] = 1'b1;
        repeat (10) tick();
        check("t3_early_ack", ack_order.size(), 0);
        check("t3_early_nib", got.size(), 0);
        check("t3_wait_state", state_out, 2'd1);
        encrypters_result_valid[0] = 1'b1;
        repeat (15) tick();
        encrypters_result_valid[1] = 1'b1;
        wait_done("t3_done", 100);
        check("t3_nacks", ack_order.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < ack_order.size()) check($sformatf("t3_order%0d", i), ack_order[i], i);
        end
        compare_stream("t3");

        // 4: backpressure holds the third nibble
        manual();
        clear_logs();
        encrypters_result[0] = 32'hA5C3E1F0;
        encrypters_result_valid[0] = 1'b1;
        qspi_ready = 1'b0;
        push_pkt(32'hA5C3E1F0);
        finish_exp();
        start_run(16'd1);
        for (int c = 0; c < 20 && !qspi_valid; c++) tick();
        check("t4_valid_up", qspi_valid, 1'b1);
        check("t4_first", qspi_data, 4'hA);
        qspi_ready = 1'b1;
        repeat (2) tick();
        qspi_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t4_hold%0d", c), {qspi_valid, qspi_data}, {1'b1, 4'hC});
            tick();
        end
        check("t4_hold_end", qspi_data, 4'hC);
        qspi_ready = 1'b1;
        wait_done("t4_done", 50);
        compare_stream("t4");

        // 5a: six packets wrap the round robin
        pkt_val[0] = 32'h01234567; pkt_val[1] = 32'h89ABCDEF;
        pkt_val[2] = 32'hFEDCBA98; pkt_val[3] = 32'h76543210;
        pkt_val[4] = 32'h13579BDF; pkt_val[5] = 32'h2468ACE0;
        clear_logs();
        arm(6);
        for (int k = 0; k < 6; k++) push_pkt(pkt_val[k]);
        finish_exp();
        start_run(16'd6);
        wait_done("t5_done", 200);
        compare_stream("t5");
        check("t5_idx_done", idx_at_done, 2'd2);
        check("t5_nacks", ack_order.size(), 6);
        if (ack_order.size() == 6) begin
            check("t5_ack5", ack_order[4], 0);
            check("t5_ack6", ack_order[5], 1);
        end

        // 5b: reset in the middle of the sixth packet
        clear_logs();
        arm(6);
        ack_total = 0;
        start_run(16'd6);
        for (int c = 0; c < 200 && ack_total < 6; c++) tick();
        check("t5r_sixth_ack", ack_total, 6);
        repeat (3) tick();
        check("t5r_mid_shift", state_out, 2'd2);
        reset = 1'b1;
        #1;
        check("t5r_outs", {qspi_valid, qspi_data, encrypters_result_ack, busy, done, state_out, encrypter_index_out}, 15'd0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("t5r_no_reack", ack_total, 6);
        check("t5r_idle", {busy, state_out, qspi_valid}, 4'd0);

        // 6: single packet, checksum nibble follows when enabled
        manual();
        clear_logs();
        encrypters_result[0] = 32'h12345678;
        encrypters_result_valid[0] = 1'b1;
        for (int k = 1; k <= 8; k++) exp_q.push_back(4'(k));
`ifdef COLLECTOR_CHECKSUM_EN
        exp_q.push_back(4'h8);
`endif
        start_run(16'd1);
        wait_done("t6_done", 50);
        compare_stream("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
